adder_tree_sequencer: RTL

//   Time-multiplexes one combinational adder_tree across N_SLICES input slices of 2-bit

---
 rtl/adder_tree_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/adder_tree_sequencer.sv
// Time-multiplexes one external adder tree over N_SLICES slices of 2-bit weights into one total.
// Optional `define SEQ_SKIP_ZERO_EN skips all-zero slices (variable latency, identical results).
module adder_tree_sequencer #(
  parameter int N_STAGE  = 2,
  parameter int N_SLICES = 4,
  parameter int TREE_W   = 2 ** (N_STAGE + 1),
  parameter int SUM_W    = N_STAGE + 2,
  parameter int IN_W     = N_SLICES * TREE_W,
  parameter int ACC_W    = N_STAGE + 2 + $clog2(N_SLICES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IN_W-1:0]   in_wx,
  output logic              busy,
  output logic [TREE_W-1:0] tree_wx,
  input  logic [SUM_W-1:0]  tree_sum,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready
);
  localparam int IDX_W = $clog2(N_SLICES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IN_W-1:0]  slices;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [IDX_W-1:0] cur;
  logic             capture, handoff, last, zero_capture;

  assign acc_nxt = acc + {{(ACC_W - SUM_W){1'b0}}, tree_sum};

`ifdef SEQ_SKIP_ZERO_EN
  logic [N_SLICES-1:0] pending, pending_rest, in_pend, cur_hot;

  // Work on the lowest still-pending non-zero slice.
  always_comb begin
    in_pend = '0;
    for (int k = 0; k < N_SLICES; k++) in_pend[k] = |in_wx[k*TREE_W +: TREE_W];
    cur = '0;
    for (int k = N_SLICES - 1; k >= 0; k--) if (pending[k]) cur = IDX_W'(k);
    cur_hot      = '0;
    cur_hot[cur] = 1'b1;
    pending_rest = pending & ~cur_hot;
    last         = (pending_rest == '0);
    zero_capture = (in_pend == '0);
  end
`else
  logic [IDX_W-1:0] idx;

  always_comb begin
    cur          = idx;
    last         = (idx == IDX_W'(N_SLICES - 1));
    zero_capture = 1'b0;
  end
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    handoff   = 1'b0;
    tree_wx   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        tree_wx = slices[int'(cur) * TREE_W +: TREE_W];
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (sum_ready) begin
          handoff = 1'b1;
          if (start) begin
            capture   = 1'b1;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing to run for an all-zero capture: the result (0) is ready at once.
    if (capture && zero_capture) state_nxt = DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slices    <= '0;
      acc       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SEQ_SKIP_ZERO_EN
      pending   <= '0;
`else
      idx       <= '0;
`endif
    end else begin
      busy <= (state_nxt != IDLE);
      if (handoff) sum_valid <= 1'b0;
      if (state == RUN) begin
        acc <= acc_nxt;
`ifdef SEQ_SKIP_ZERO_EN
        pending <= pending_rest;
`else
        idx <= idx + IDX_W'(1);
`endif
        if (last) begin
          sum_out   <= acc_nxt;
          sum_valid <= 1'b1;
        end
      end
      if (capture) begin
        slices <= in_wx;
        acc    <= '0;
`ifdef SEQ_SKIP_ZERO_EN
        pending <= in_pend;
`else
        idx <= '0;
`endif
        if (zero_capture) begin
          sum_out   <= '0;
          sum_valid <= 1'b1;
        end
      end
    end
  end

endmodule
